// File: rtl/gate1_rr_sched.sv
// Round-robin scheduler sharing one inverting 4:1 mux cell (gate1) among four requesters.
// Each grant drives the cell, waits SETTLE cycles, returns ~o and flags a mismatch against the requester's bit.
module gate1_rr_sched #(
  parameter int SETTLE = 1,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [3:0] din,
  input  logic       o,
  output logic       s0,
  output logic       s1,
  output logic       i0,
  output logic       i1,
  output logic       i2,
  output logic       i3,
  output logic [3:0] ack,
  output logic       dout,
  output logic       busy,
  output logic       err
);

  generate
    if ((SETTLE < 1) || (SETTLE > 15) || ((2 ** CW) <= SETTLE)) begin : g_bad_params
      $error("gate1_rr_sched: SETTLE must be 1..15 and fit in CW bits");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    sel;
  logic [1:0]    pick;
  logic          hit;
  logic          exp_bit;
  logic [CW-1:0] cnt;

  // First active requester at or after ptr, wrapping modulo 4.
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!hit && req[ptr + 2'(i)]) begin
        pick = ptr + 2'(i);
        hit  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      ptr              <= '0;
      sel              <= '0;
      exp_bit          <= 1'b0;
      cnt              <= '0;
      {s0, s1}         <= 2'b00;
      {i3, i2, i1, i0} <= 4'b0000;
      ack              <= 4'b0000;
      dout             <= 1'b0;
      busy             <= 1'b0;
      err              <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            sel              <= pick;
            {s0, s1}         <= pick;
            {i3, i2, i1, i0} <= din;
            exp_bit          <= din[pick];
            cnt              <= CW'(SETTLE - 1);
            busy             <= 1'b1;
            state            <= DRIVE;
          end
        end
        DRIVE: begin
          // Cell inputs stay frozen; o is sampled once the settle window has elapsed.
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            dout  <= ~o;
            ack   <= 4'b0001 << sel;
            err   <= (~o) != exp_bit;
            ptr   <= sel + 2'd1;
            state <= DONE;
          end
        end
        DONE: begin
          ack   <= 4'b0000;
          err   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate1_rr_sched.sv
// Scoreboard bench for gate1_rr_sched: a behavioural gate1 cell answers the DUT, expected grants are
// queued as stimulus is applied and compared whenever an ack pulse appears.
module tb_gate1_rr_sched;

  localparam int SETTLE = 3;
  localparam int CW     = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] din;
  logic       o;
  logic       s0, s1, i0, i1, i2, i3;
  logic [3:0] ack;
  logic       dout, busy, err;
  logic [3:0] iv;

  typedef struct {
    logic [3:0] ack;
    logic       dout;
    logic       err;
    logic [1:0] sel;
    logic [3:0] snap;
  } exp_t;

  exp_t sbQ[$];
  int   checks       = 0;
  int   failures     = 0;
  int   cycleNo      = 0;
  int   lastAckCycle = -1;
  logic lastDout     = 1'b0;
  bit   autoDrop     = 1'b0;
  bit   forceO       = 1'b0;

  always #5 clk = ~clk;

  // Behavioural gate1 cell: inverting 4:1 mux, optionally stuck at 1 to inject a fault.
  assign iv = {i3, i2, i1, i0};
  always_comb o = forceO ? 1'b1 : ~iv[{s0, s1}];

  gate1_rr_sched #(.SETTLE(SETTLE), .CW(CW)) dut (
    .clk(clk), .rst(rst), .req(req), .din(din), .o(o),
    .s0(s0), .s1(s1), .i0(i0), .i1(i1), .i2(i2), .i3(i3),
    .ack(ack), .dout(dout), .busy(busy), .err(err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cycleNo);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] reqVal, input logic [3:0] dinVal);
    req = reqVal;
    din = dinVal;
  endtask

  task automatic pushExpect(input int k, input logic [3:0] snap);
    exp_t it;
    logic oModel;
    oModel  = forceO ? 1'b1 : ~snap[k];
    it.ack  = 4'b0001 << k;
    it.dout = ~oModel;
    it.err  = (~oModel) != snap[k];
    it.sel  = 2'(k);
    it.snap = snap;
    sbQ.push_back(it);
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_ack"},  ack, 4'b0000);
    checkOutput({tag, "_dout"}, dout, 1'b0);
    checkOutput({tag, "_busy"}, busy, 1'b0);
    checkOutput({tag, "_err"},  err, 1'b0);
    checkOutput({tag, "_sel"},  {s0, s1}, 2'b00);
    checkOutput({tag, "_i"},    {i3, i2, i1, i0}, 4'b0000);
  endtask

  // One clock: outputs are examined on the falling edge, then inputs are updated for the next rising edge.
  task automatic stepCycle(input bit toggleDin);
    exp_t it;
    @(negedge clk);
    cycleNo++;
    if (ack != 4'b0000) begin
      checkOutput("ack_onehot", $countones(ack), 1);
      checkOutput("ack_busy", busy, 1'b1);
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_ack", ack, 4'b0000);
      end else begin
        it = sbQ.pop_front();
        checkOutput("ack", ack, it.ack);
        checkOutput("dout", dout, it.dout);
        checkOutput("err", err, it.err);
        if (lastAckCycle >= 0)
          checkOutput("ack_spacing", cycleNo - lastAckCycle, SETTLE + 2);
      end
      lastAckCycle = cycleNo;
      lastDout     = dout;
      if (autoDrop) req = req & ~ack;
    end else begin
      checkOutput("err_no_ack", err, 1'b0);
      checkOutput("dout_hold", dout, lastDout);
      if (busy && sbQ.size() != 0) begin
        checkOutput("drive_sel", {s0, s1}, sbQ[0].sel);
        checkOutput("drive_i", {i3, i2, i1, i0}, sbQ[0].snap);
      end
    end
    if (toggleDin) din = ~din;
  endtask

  task automatic waitDrain(input int limit, input bit toggleDin);
    int n = 0;
    while (sbQ.size() != 0 && n < limit) begin
      stepCycle(toggleDin);
      n++;
    end
    if (sbQ.size() != 0) begin
      checkOutput("drain_timeout", sbQ.size(), 0);
      sbQ.delete();
    end
  endtask

  initial begin
    int n;
    rst = 1'b1;
    applyStimulus(4'hF, 4'b0000);
    for (int c = 0; c < 3; c++) stepCycle(0);
    checkIdleOutputs("reset");

    // All four requesting out of reset: strict rotation 0,1,2,3.
    din      = 4'b1010;
    autoDrop = 1'b1;
    for (int k = 0; k < 4; k++) pushExpect(k, din);
    rst = 1'b0;
    waitDrain(40, 0);
    for (int c = 0; c < 4; c++) stepCycle(0);

    // ptr has wrapped back to 0, so 0 is served before 3.
    lastAckCycle = -1;
    applyStimulus(4'b1001, 4'b0001);
    pushExpect(0, din);
    pushExpect(3, din);
    waitDrain(30, 0);
    for (int c = 0; c < 3; c++) stepCycle(0);

    // A persistent single requester is re-granted with one IDLE cycle between grants.
    lastAckCycle = -1;
    autoDrop     = 1'b0;
    applyStimulus(4'b0100, 4'b0100);
    pushExpect(2, din);
    pushExpect(2, din);
    waitDrain(30, 0);
    req = 4'b0000;
    for (int c = 0; c < 3; c++) stepCycle(0);

    // Stuck-at-1 cell output while the selected bit is 1: dout=0 and err pulses with ack.
    lastAckCycle = -1;
    autoDrop     = 1'b1;
    forceO       = 1'b1;
    applyStimulus(4'b0010, 4'b0010);
    pushExpect(1, din);
    waitDrain(20, 0);
    forceO = 1'b0;
    for (int c = 0; c < 3; c++) stepCycle(0);

    // Reset in the second DRIVE cycle aborts the grant silently and clears ptr.
    lastAckCycle = -1;
    applyStimulus(4'b0100, 4'b0100);
    n = 0;
    do begin
      stepCycle(0);
      n++;
    end while (!busy && n < 10);
    checkOutput("abort_reached_drive", busy, 1'b1);
    stepCycle(0);
    checkOutput("abort_second_drive", {busy, ack}, {1'b1, 4'b0000});
    rst      = 1'b1;
    lastDout = 1'b0;
    applyStimulus(4'b1001, 4'b1000);
    stepCycle(0);
    stepCycle(0);
    checkIdleOutputs("abort");
    pushExpect(0, din);
    pushExpect(3, din);
    rst = 1'b0;
    waitDrain(30, 0);
    for (int c = 0; c < 3; c++) stepCycle(0);

    // din toggles every cycle and req drops mid-DRIVE; the grant-time snapshot must still be served.
    lastAckCycle = -1;
    applyStimulus(4'b0010, 4'b0010);
    pushExpect(1, din);
    stepCycle(1);
    req = 4'b0000;
    waitDrain(20, 1);
    for (int c = 0; c < 4; c++) stepCycle(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
